// File: rtl/core_seq_ctrl.sv
// Layer sequencer for core_top: walks ocg/row/col/cycle loops, issues buffer reads
// and emits per-pixel flush/bias/valid control delayed to meet the buffer read data.
module core_seq_ctrl #(
    parameter int AW     = 16,
    parameter int CW     = 10,
    parameter int DW_RC  = 9,
    parameter int GW     = 6,
    parameter int RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CW-1:0]    cfg_n_cyc,
    input  logic [DW_RC-1:0] cfg_n_row,
    input  logic [DW_RC-1:0] cfg_n_col,
    input  logic [GW-1:0]    cfg_n_ocg,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    act_addr,
    output logic [AW-1:0]    wgt_addr,
    output logic             o_core_vld,
    output logic             o_flush,
    output logic             o_sel_bias,
    output logic [GW-1:0]    o_bias_idx,
    output logic [DW_RC-1:0] o_row,
    output logic [DW_RC-1:0] o_col
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam int PW = 3 + GW + 2 * DW_RC;
    localparam int DRN_INIT_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [1:0] DRN_INIT = DRN_INIT_I[1:0];

    localparam logic [CW-1:0]    C_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]    C_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    C_TWO   = {{(CW-2){1'b0}}, 2'b10};
    localparam logic [DW_RC-1:0] RC_ZERO = {DW_RC{1'b0}};
    localparam logic [DW_RC-1:0] RC_ONE  = {{(DW_RC-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0]    G_ZERO  = {GW{1'b0}};
    localparam logic [GW-1:0]    G_ONE   = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    A_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]    A_ONE   = {{(AW-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [CW-1:0]     n_cyc_r, l_r;
    logic [DW_RC-1:0]  n_row_r, n_col_r, row_r, col_r;
    logic [GW-1:0]     n_ocg_r, ocg_r;
    logic [AW-1:0]     act_cnt_r, wgt_base_r, act_addr_r, wgt_addr_r;
    logic [1:0]        drn_r;
    logic              busy_r, done_r, rd_en_r;
    logic              iss_vld_r, iss_flush_r, iss_sel_r;
    logic [GW-1:0]     iss_ocg_r;
    logic [DW_RC-1:0]  iss_row_r, iss_col_r;

    logic              cfg_ok_s, last_l_s, last_col_s, last_row_s, last_ocg_s, last_issue_s;
    logic [CW-1:0]     nxt_l_s;
    logic [DW_RC-1:0]  nxt_row_s, nxt_col_s;
    logic [GW-1:0]     nxt_ocg_s;
    logic              ocg_adv_s, nxt_bias_s;
    logic [AW-1:0]     nxt_base_s, nxt_act_s;
    logic [PW-1:0]     iss_pk_s, out_pk_s;

    assign cfg_ok_s     = (cfg_n_cyc >= C_TWO) && (cfg_n_row != RC_ZERO) &&
                          (cfg_n_col != RC_ZERO) && (cfg_n_ocg != G_ZERO);
    assign last_l_s     = (l_r == n_cyc_r - C_ONE);
    assign last_col_s   = (col_r == n_col_r - RC_ONE);
    assign last_row_s   = (row_r == n_row_r - RC_ONE);
    assign last_ocg_s   = (ocg_r == n_ocg_r - G_ONE);
    assign last_issue_s = last_l_s && last_col_s && last_row_s && last_ocg_s;

    // Loop-nest successor of the issue currently held in the issue register.
    always_comb begin
        nxt_l_s   = l_r + C_ONE;
        nxt_col_s = col_r;
        nxt_row_s = row_r;
        nxt_ocg_s = ocg_r;
        ocg_adv_s = 1'b0;
        if (last_l_s) begin
            nxt_l_s = C_ZERO;
            if (last_col_s) begin
                nxt_col_s = RC_ZERO;
                if (last_row_s) begin
                    nxt_row_s = RC_ZERO;
                    nxt_ocg_s = ocg_r + G_ONE;
                    ocg_adv_s = 1'b1;
                end else begin
                    nxt_row_s = row_r + RC_ONE;
                end
            end else begin
                nxt_col_s = col_r + RC_ONE;
            end
        end else begin
            nxt_col_s = col_r;
        end
    end

    assign nxt_bias_s = (nxt_l_s == n_cyc_r - C_ONE);
    assign nxt_base_s = ocg_adv_s ? (wgt_base_r + AW'(n_cyc_r - C_ONE)) : wgt_base_r;
    assign nxt_act_s  = ocg_adv_s ? A_ZERO : act_cnt_r;

    // Sequencer FSM: loop counters, address generation and the issue register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= IDLE;
            n_cyc_r     <= C_ZERO;
            n_row_r     <= RC_ZERO;
            n_col_r     <= RC_ZERO;
            n_ocg_r     <= G_ZERO;
            l_r         <= C_ZERO;
            row_r       <= RC_ZERO;
            col_r       <= RC_ZERO;
            ocg_r       <= G_ZERO;
            act_cnt_r   <= A_ZERO;
            wgt_base_r  <= A_ZERO;
            act_addr_r  <= A_ZERO;
            wgt_addr_r  <= A_ZERO;
            drn_r       <= 2'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            iss_vld_r   <= 1'b0;
            iss_flush_r <= 1'b0;
            iss_sel_r   <= 1'b0;
            iss_ocg_r   <= G_ZERO;
            iss_row_r   <= RC_ZERO;
            iss_col_r   <= RC_ZERO;
        end else begin
            rd_en_r     <= 1'b0;
            iss_vld_r   <= 1'b0;
            iss_flush_r <= 1'b0;
            iss_sel_r   <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    busy_r <= start;
                    if (start) begin
                        n_cyc_r <= cfg_n_cyc;
                        n_row_r <= cfg_n_row;
                        n_col_r <= cfg_n_col;
                        n_ocg_r <= cfg_n_ocg;
                        if (cfg_ok_s) begin
                            state_r     <= RUN;
                            l_r         <= C_ZERO;
                            row_r       <= RC_ZERO;
                            col_r       <= RC_ZERO;
                            ocg_r       <= G_ZERO;
                            wgt_base_r  <= A_ZERO;
                            act_cnt_r   <= A_ONE;
                            act_addr_r  <= A_ZERO;
                            wgt_addr_r  <= A_ZERO;
                            rd_en_r     <= 1'b1;
                            iss_vld_r   <= 1'b1;
                            iss_flush_r <= 1'b1;
                            iss_ocg_r   <= G_ZERO;
                            iss_row_r   <= RC_ZERO;
                            iss_col_r   <= RC_ZERO;
                        end else begin
                            // Degenerate layer: one settle cycle, then the done pulse.
                            state_r <= DRAIN;
                            drn_r   <= 2'd0;
                        end
                    end
                end
                RUN: begin
                    if (last_issue_s) begin
                        if (RD_LAT == 0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                            drn_r   <= DRN_INIT;
                        end
                    end else if (!stall) begin
                        l_r         <= nxt_l_s;
                        col_r       <= nxt_col_s;
                        row_r       <= nxt_row_s;
                        ocg_r       <= nxt_ocg_s;
                        wgt_base_r  <= nxt_base_s;
                        rd_en_r     <= ~nxt_bias_s;
                        iss_vld_r   <= 1'b1;
                        iss_flush_r <= (nxt_l_s == C_ZERO);
                        iss_sel_r   <= nxt_bias_s;
                        iss_ocg_r   <= nxt_ocg_s;
                        iss_row_r   <= nxt_row_s;
                        iss_col_r   <= nxt_col_s;
                        if (!nxt_bias_s) begin
                            act_addr_r <= nxt_act_s;
                            act_cnt_r  <= nxt_act_s + A_ONE;
                            wgt_addr_r <= nxt_base_s + AW'(nxt_l_s);
                        end
                    end
                end
                DRAIN: begin
                    if (drn_r == 2'd0) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        drn_r <= drn_r - 2'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign iss_pk_s = {iss_vld_r, iss_flush_r, iss_sel_r, iss_ocg_r, iss_row_r, iss_col_r};

    generate
        if (RD_LAT == 0) begin : g_nodly
            assign out_pk_s = iss_pk_s;
        end else begin : g_dly
            logic [PW-1:0] dly_r [RD_LAT];
            // Control delay line matching the buffer read latency.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        dly_r[i] <= {PW{1'b0}};
                    end
                end else begin
                    dly_r[0] <= iss_pk_s;
                    for (int i = 1; i < RD_LAT; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end
            assign out_pk_s = dly_r[RD_LAT-1];
        end
    endgenerate

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_en    = rd_en_r;
    assign act_addr = act_addr_r;
    assign wgt_addr = wgt_addr_r;
    assign {o_core_vld, o_flush, o_sel_bias, o_bias_idx, o_row, o_col} = out_pk_s;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: nested-loop reference model feeds address/flag queues that
// are popped as rd_en and o_core_vld appear; a second RD_LAT=2 instance runs a long profile.
module tb_core_seq_ctrl;

    localparam int AW = 16;
    localparam int CW = 10;
    localparam int DW = 9;
    localparam int GW = 6;
    localparam int FW = 2 + GW + 2 * DW;
    localparam int OW = 3 + 2 * AW + 3 + GW + 2 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start = 1'b0, stall = 1'b0;
    logic [CW-1:0] cfg_n_cyc = '0;
    logic [DW-1:0] cfg_n_row = '0, cfg_n_col = '0;
    logic [GW-1:0] cfg_n_ocg = '0;
    logic          busy, done, rd_en, o_core_vld, o_flush, o_sel_bias;
    logic [AW-1:0] act_addr, wgt_addr;
    logic [GW-1:0] o_bias_idx;
    logic [DW-1:0] o_row, o_col;

    logic          start2 = 1'b0, stall2 = 1'b0;
    logic [CW-1:0] cfg2_n_cyc = '0;
    logic [DW-1:0] cfg2_n_row = '0, cfg2_n_col = '0;
    logic [GW-1:0] cfg2_n_ocg = '0;
    logic          busy2, done2, rd_en2, o_core_vld2, o_flush2, o_sel_bias2;
    logic [AW-1:0] act_addr2, wgt_addr2;
    logic [GW-1:0] o_bias_idx2;
    logic [DW-1:0] o_row2, o_col2;

    core_seq_ctrl #(.AW(AW), .CW(CW), .DW_RC(DW), .GW(GW), .RD_LAT(1)) dut (
        .CLK(clk), .RST(rst_n), .start(start), .cfg_n_cyc(cfg_n_cyc), .cfg_n_row(cfg_n_row),
        .cfg_n_col(cfg_n_col), .cfg_n_ocg(cfg_n_ocg), .stall(stall), .busy(busy), .done(done),
        .rd_en(rd_en), .act_addr(act_addr), .wgt_addr(wgt_addr), .o_core_vld(o_core_vld),
        .o_flush(o_flush), .o_sel_bias(o_sel_bias), .o_bias_idx(o_bias_idx),
        .o_row(o_row), .o_col(o_col));

    core_seq_ctrl #(.AW(AW), .CW(CW), .DW_RC(DW), .GW(GW), .RD_LAT(2)) dut2 (
        .CLK(clk), .RST(rst_n), .start(start2), .cfg_n_cyc(cfg2_n_cyc), .cfg_n_row(cfg2_n_row),
        .cfg_n_col(cfg2_n_col), .cfg_n_ocg(cfg2_n_ocg), .stall(stall2), .busy(busy2),
        .done(done2), .rd_en(rd_en2), .act_addr(act_addr2), .wgt_addr(wgt_addr2),
        .o_core_vld(o_core_vld2), .o_flush(o_flush2), .o_sel_bias(o_sel_bias2),
        .o_bias_idx(o_bias_idx2), .o_row(o_row2), .o_col(o_col2));

    wire [OW-1:0] all_out  = {busy, done, rd_en, act_addr, wgt_addr, o_core_vld, o_flush,
                              o_sel_bias, o_bias_idx, o_row, o_col};
    wire [OW-1:0] all_out2 = {busy2, done2, rd_en2, act_addr2, wgt_addr2, o_core_vld2,
                              o_flush2, o_sel_bias2, o_bias_idx2, o_row2, o_col2};

    int checks = 0;
    int errors = 0;

    logic [2*AW-1:0] addr_q [$];
    logic [FW-1:0]   flag_q [$];
    int n_rd, n_vld, n_flush, n_sel, n_done, done_cyc, first_vld, last_vld, last_flush;
    int start_cyc;
    bit chk_spacing;
    int exp_spacing;

    task automatic clear_stats();
        n_rd = 0; n_vld = 0; n_flush = 0; n_sel = 0; n_done = 0; done_cyc = -1;
        first_vld = -1; last_vld = -1; last_flush = -1;
        addr_q.delete();
        flag_q.delete();
    endtask

    // Builds the expected sequence with a plain loop nest, then pulses start.
    task automatic begin_layer(input int nc, input int nr, input int ncl, input int no);
        logic [AW-1:0] act, base;
        logic [FW-1:0] f;
        clear_stats();
        exp_spacing = nc;
        if (nc >= 2 && nr > 0 && ncl > 0 && no > 0) begin
            for (int o = 0; o < no; o++) begin
                act  = '0;
                base = AW'(o * (nc - 1));
                for (int r = 0; r < nr; r++)
                    for (int c = 0; c < ncl; c++)
                        for (int l = 0; l < nc; l++) begin
                            if (l < nc - 1) begin
                                addr_q.push_back({act, base + AW'(l)});
                                act = act + 16'd1;
                                f = {(l == 0), 1'b0, GW'(o), DW'(r), DW'(c)};
                            end else begin
                                f = {1'b0, 1'b1, GW'(o), DW'(r), DW'(c)};
                            end
                            flag_q.push_back(f);
                        end
            end
        end
        @(negedge clk);
        cfg_n_cyc = CW'(nc); cfg_n_row = DW'(nr); cfg_n_col = DW'(ncl); cfg_n_ocg = GW'(no);
        stall = 1'b0;
        start = 1'b1;
        start_cyc = cyc;
    endtask

    // Scoreboard pop/compare for the RD_LAT=1 instance, called once per negedge.
    task automatic sample_dut1();
        logic [2*AW-1:0] ea;
        logic [FW-1:0]   ef;
        if (rd_en) begin
            n_rd++;
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL extra_rd_en: got act=%0d wgt=%0d, required no read", act_addr, wgt_addr);
            end else begin
                ea = addr_q.pop_front();
                if ({act_addr, wgt_addr} !== ea) begin
                    errors++;
                    $display("FAIL addr[%0d]: got act=%0d wgt=%0d, required act=%0d wgt=%0d",
                             n_rd - 1, act_addr, wgt_addr, ea[2*AW-1:AW], ea[AW-1:0]);
                end
            end
        end
        checks++;
        if (!o_core_vld && (o_flush || o_sel_bias)) begin
            errors++;
            $display("FAIL bubble_flags: got flush=%b sel=%b with vld=0, required 0", o_flush, o_sel_bias);
        end
        if (o_core_vld) begin
            n_vld++;
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
            checks++;
            if (flag_q.size() == 0) begin
                errors++;
                $display("FAIL extra_vld: got vld at cycle %0d, required none", cyc - start_cyc);
            end else begin
                ef = flag_q.pop_front();
                if ({o_flush, o_sel_bias, o_bias_idx, o_row, o_col} !== ef) begin
                    errors++;
                    $display("FAIL flags[%0d]: got f=%b s=%b g=%0d r=%0d c=%0d, required f=%b s=%b g=%0d r=%0d c=%0d",
                             n_vld - 1, o_flush, o_sel_bias, o_bias_idx, o_row, o_col,
                             ef[FW-1], ef[FW-2], ef[2*DW+GW-1:2*DW], ef[2*DW-1:DW], ef[DW-1:0]);
                end
            end
            if (o_sel_bias) n_sel++;
            if (o_flush) begin
                n_flush++;
                if (chk_spacing && last_flush >= 0) begin
                    checks++;
                    if (cyc - last_flush != exp_spacing) begin
                        errors++;
                        $display("FAIL flush_spacing: got %0d, required %0d", cyc - last_flush, exp_spacing);
                    end
                end
                last_flush = cyc;
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic run_layer(input int budget, input int stall_from, input int stall_len,
                             input int restart_off, input int exp_done, input int exp_gaps);
        int off;
        int tail = 0;
        int gaps;
        bit seen = 1'b0;
        for (int i = 0; i < budget && tail < 2; i++) begin
            @(negedge clk);
            sample_dut1();
            off = cyc - start_cyc;
            if (off == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_start: got %b, required 1", busy);
                end
            end
            if (seen) tail++;
            if (done) seen = 1'b1;
            start = (off == restart_off);
            stall = (off >= stall_from) && (off < stall_from + stall_len);
        end
        start = 1'b0;
        stall = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        end
        checks++;
        if (done_cyc - start_cyc != exp_done || n_done != 1) begin
            errors++;
            $display("FAIL done_timing: got cycle %0d (%0d pulses), required cycle %0d (1 pulse)",
                     done_cyc - start_cyc, n_done, exp_done);
        end
        checks++;
        if (addr_q.size() != 0 || flag_q.size() != 0) begin
            errors++;
            $display("FAIL missing_issues: got %0d reads / %0d flags outstanding, required 0 / 0",
                     addr_q.size(), flag_q.size());
        end
        gaps = (n_vld > 0) ? (last_vld - first_vld + 1 - n_vld) : 0;
        checks++;
        if (gaps != exp_gaps) begin
            errors++;
            $display("FAIL vld_bubbles: got %0d, required %0d", gaps, exp_gaps);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done: got %b, required 0", busy);
        end
    endtask

    task automatic check_counts(input string tag, input int e_rd, input int e_vld,
                                input int e_flush, input int e_sel);
        checks++;
        if (n_rd != e_rd || n_vld != e_vld || n_flush != e_flush || n_sel != e_sel) begin
            errors++;
            $display("FAIL %s_counts: got rd=%0d vld=%0d flush=%0d sel=%0d, required %0d %0d %0d %0d",
                     tag, n_rd, n_vld, n_flush, n_sel, e_rd, e_vld, e_flush, e_sel);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== {OW{1'b0}} || all_out2 !== {OW{1'b0}}) begin
            errors++;
            $display("FAIL reset_state: got %h / %h, required 0", all_out, all_out2);
        end
    endtask

    task automatic test_nominal();
        chk_spacing = 1'b1;
        begin_layer(4, 2, 2, 2);
        run_layer(80, -10, 0, -1, 34, 0);
        check_counts("nominal", 24, 32, 8, 8);
        checks++;
        if (first_vld - start_cyc != 2) begin
            errors++;
            $display("FAIL flag_latency: got first vld at %0d, required 2", first_vld - start_cyc);
        end
    endtask

    task automatic test_stall();
        chk_spacing = 1'b0;
        begin_layer(4, 2, 2, 2);
        run_layer(80, 6, 3, -1, 37, 3);
        check_counts("stall", 24, 32, 8, 8);
    endtask

    task automatic test_bad_cfg();
        chk_spacing = 1'b0;
        begin_layer(4, 0, 2, 2);
        run_layer(20, -10, 0, -1, 2, 0);
        check_counts("row0", 0, 0, 0, 0);
        begin_layer(1, 2, 2, 2);
        run_layer(20, -10, 0, -1, 2, 0);
        check_counts("cyc1", 0, 0, 0, 0);
    endtask

    task automatic test_restart_ignored();
        chk_spacing = 1'b1;
        begin_layer(4, 2, 2, 2);
        @(posedge clk);
        #1;
        cfg_n_cyc = 10'd7; cfg_n_row = 9'd5; cfg_n_col = 9'd3; cfg_n_ocg = 6'd9;
        run_layer(80, -10, 0, 10, 34, 0);
        check_counts("restart", 24, 32, 8, 8);
    endtask

    task automatic test_mid_reset();
        bit done_seen = 1'b0;
        chk_spacing = 1'b1;
        begin_layer(4, 2, 2, 2);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            sample_dut1();
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out !== {OW{1'b0}}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h, required 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || rd_en || busy) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL mid_reset_quiet: got done/rd_en/busy activity after abort, required none");
        end
        begin_layer(4, 2, 2, 2);
        run_layer(80, -10, 0, -1, 34, 0);
        check_counts("replay", 24, 32, 8, 8);
    endtask

    // Scaled layer-8 profile on the RD_LAT=2 instance: 144 cycles, 4x4 pixels, 4 groups.
    task automatic test_layer8_profile();
        int s_cyc, fl = 0, sl = 0, d_off = -1, first_rd = -1, first_fl = -1, tail = 0;
        logic [AW-1:0] last_wgt = '0;
        logic [GW-1:0] last_idx = '0;
        @(negedge clk);
        cfg2_n_cyc = 10'd144; cfg2_n_row = 9'd4; cfg2_n_col = 9'd4; cfg2_n_ocg = 6'd4;
        start2 = 1'b1;
        s_cyc = cyc;
        for (int i = 0; i < 12000 && tail < 2; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (rd_en2) begin
                last_wgt = wgt_addr2;
                if (first_rd < 0) first_rd = cyc - s_cyc;
            end
            if (o_core_vld2 && o_flush2) begin
                fl++;
                if (first_fl < 0) first_fl = cyc - s_cyc;
            end
            if (o_core_vld2 && o_sel_bias2) begin
                sl++;
                last_idx = o_bias_idx2;
            end
            if (d_off >= 0) tail++;
            if (done2) d_off = cyc - s_cyc;
        end
        checks++;
        if (fl != 64 || sl != 64) begin
            errors++;
            $display("FAIL l8_pulses: got flush=%0d sel=%0d, required 64 64", fl, sl);
        end
        checks++;
        if (last_wgt !== 16'd571) begin
            errors++;
            $display("FAIL l8_final_wgt: got %0d, required 571", last_wgt);
        end
        checks++;
        if (d_off != 9219) begin
            errors++;
            $display("FAIL l8_done: got cycle %0d, required 9219", d_off);
        end
        checks++;
        if (first_rd != 1 || first_fl != 3) begin
            errors++;
            $display("FAIL l8_latency: got rd@%0d flush@%0d, required rd@1 flush@3", first_rd, first_fl);
        end
        checks++;
        if (last_idx !== 6'd3 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL l8_tail: got idx=%0d busy=%b, required idx=3 busy=0", last_idx, busy2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_bad_cfg();
        test_restart_ignored();
        test_mid_reset();
        test_layer8_profile();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
